word_packer: RTL and testbench
==============================

Name: word_packer

Overview:
- Sits directly downstream of the 4-lane SSSP update filter.
- The filter delivers up to four 64-bit words per cycle, already compacted so that valid words occupy lanes 0..n-1.
- This block concatenates those variable-size beats into dense 4-word lines for the memory write path.
- On the final beat of a pass it flushes any residual words as one partial line, marked by a mask and a last flag.

Parameters:
- W, 64, width of one word in bits.
- CNT_W, 32, width of the accepted-word counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- last_input_in  in  1  marks the current beat as the final beat of the pass; may be asserted with n=0.
- word_in_valid  in  [3:0] (unpacked, 1 bit each)  lane valids; always contiguous from lane 0.
- word_in  in  [3:0] x W  lane data.
- line_out_valid  out  1  single-cycle pulse: line_out is valid.
- line_out  out  [3:0] x W  packed line; lane 0 holds the oldest word.
- line_out_mask  out  [3:0]  lanes of line_out that hold real data.
- last_line_out  out  1  qualifies the final line of a pass.
- words_total  out  CNT_W  words accepted since reset.

Behaviour:
- Reset (async assert, sync release). All outputs are 0. Holding buffer count cnt=0. State=RUN.
- Input count. n = number of valid lanes (0..4). A non-contiguous valid pattern is a protocol violation and its behaviour is undefined.
- Holding buffer. buf[0..2] with cnt in 0..3. The invariant cnt<=3 holds after every cycle.
- No backpressure. The block never stalls upstream and emits at most one line per cycle. All outputs are registered, so latency is 1 cycle from the beat that completes a line.
- RUN, per beat, with total = cnt+n:
  - total>=4: the next cycle emits line = buf[0..cnt-1] followed by in[0..3-cnt], with mask=1111. The new buf is in[4-cnt..n-1] and the new cnt is total-4.
  - total<4: in[0..n-1] is appended at buf[cnt..]; cnt=total; no output.
  - n=0 and last_input_in=0: nothing changes.
- Last beat in RUN (last_input_in=1), after the packing above:
  - total>=4 and residual 0: the emitted full line carries last_line_out=1. Stay in RUN with cnt=0.
  - total>=4 and residual r>0: the full line is emitted with last=0. Go to FLUSH. In the FLUSH cycle, emit buf[0..r-1], zero padding, mask = low r bits set, last=1. Then return to RUN with cnt=0.
  - 0<total<4: the next cycle emits a partial line with the combined words, mask for total lanes, last=1. cnt=0.
  - total==0: the next cycle emits a terminator line with data 0, mask=0000, valid=1, last=1.
- Between passes. Upstream guarantees no valid lanes and no last_input_in while in FLUSH. The bench must respect this.
- Padding. Unused lanes of line_out are driven to 0.
- When not valid. line_out_mask, last_line_out and line_out hold 0 while line_out_valid=0.
- words_total. Increments by n each cycle in RUN and wraps modulo 2^CNT_W. It is not cleared at a pass end.
- Mid-operation reset. Buffered words are discarded and outputs clear immediately. No partial line is emitted.

Test Plan:
- Reset: assert rst mid-pass with cnt=2 -> all outputs 0 at once; a later last_input_in with n=0 gives a terminator (mask 0000, last=1) with no stale words.
- Steady full beats: 3 beats of n=4 with data 0x10..0x1B -> lines {10,11,12,13}, {14,15,16,17}, {18,19,1A,1B}, each mask 1111, 1 cycle after each beat; words_total=12.
- Carry across beats: n=3 (A0..A2), then n=3 (A3..A5) -> no output after beat 1; after beat 2, line {A0,A1,A2,A3}; cnt=2 holding A4,A5.
- Flush with residual: cnt=3 (B0..B2), then last beat n=4 (B3..B6) -> cycle+1: {B0,B1,B2,B3} last=0; cycle+2: {B4,B5,B6,0} mask 0111 last=1.
- Partial and empty terminators: cnt=1 (C0) plus last beat n=1 (C1) -> {C0,C1,0,0} mask 0011 last=1. Separately, cnt=0 plus last beat n=0 -> mask 0000 last=1.
- Exact fill on last: cnt=2 plus last beat n=2 -> single line mask 1111 with last=1, no FLUSH cycle; words_total wrap checked with CNT_W=4 reaching 15 and then adding 2 -> 1.

Source files
------------

// File: rtl/word_packer.sv
// word_packer: packs 0..4 compacted words per beat into dense 4-word lines.
// Flushes residual words as a masked partial line at the end of a pass.
//
// Ports:
//   clk            clock
//   rst            asynchronous active-high reset
//   last_input_in  current beat is the final beat of the pass (n may be 0)
//   word_in_valid  lane valids, contiguous from lane 0
//   word_in        lane data
//   line_out_valid single-cycle pulse, line_out holds a line
//   line_out       packed line, lane 0 is the oldest word, unused lanes 0
//   line_out_mask  lanes of line_out that carry real data
//   last_line_out  final line of the pass
//   words_total    words accepted since reset (wraps)
module word_packer #(
    parameter int W     = 64,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             last_input_in,
    input  logic             word_in_valid [4],
    input  logic [W-1:0]     word_in [4],
    output logic             line_out_valid,
    output logic [W-1:0]     line_out [4],
    output logic [3:0]       line_out_mask,
    output logic             last_line_out,
    output logic [CNT_W-1:0] words_total
);

    typedef enum logic {
        RUN,
        FLUSH
    } state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     buf_q [3];
    logic [W-1:0]     buf_d [3];
    logic [1:0]       cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic [W-1:0]     line_q [4];
    logic [W-1:0]     line_d [4];
    logic [3:0]       mask_q, mask_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] words_q, words_d;

    logic [2:0]       n;
    logic [2:0]       fill;
    // Held words followed by the new beat; slots past fill are zero.
    logic [W-1:0]     comb [7];

    function automatic logic [3:0] low_mask(input logic [2:0] k);
        logic [3:0] m;
        case (k)
            3'd0:    m = 4'b0000;
            3'd1:    m = 4'b0001;
            3'd2:    m = 4'b0011;
            3'd3:    m = 4'b0111;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    // Valids are contiguous, so the popcount is the lane count.
    always_comb begin
        n = 3'(word_in_valid[0]) + 3'(word_in_valid[1])
          + 3'(word_in_valid[2]) + 3'(word_in_valid[3]);
        fill = {1'b0, cnt_q} + n;
    end

    always_comb begin
        for (int i = 0; i < 7; i++) begin
            comb[i] = '0;
        end
        for (int i = 0; i < 3; i++) begin
            if (2'(i) < cnt_q) begin
                comb[i] = buf_q[i];
            end
        end
        for (int j = 0; j < 4; j++) begin
            if (3'(j) < n) begin
                comb[3'(j) + {1'b0, cnt_q}] = word_in[j];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        valid_d = 1'b0;
        mask_d  = 4'b0000;
        last_d  = 1'b0;
        words_d = words_q;
        for (int i = 0; i < 4; i++) begin
            line_d[i] = '0;
        end

        unique case (state_q)
            RUN: begin
                words_d = words_q + CNT_W'(n);
                if (fill >= 3'd4) begin
                    valid_d = 1'b1;
                    mask_d  = 4'b1111;
                    for (int i = 0; i < 4; i++) begin
                        line_d[i] = comb[i];
                    end
                    for (int i = 0; i < 3; i++) begin
                        buf_d[i] = comb[i + 4];
                    end
                    cnt_d = 2'(fill - 3'd4);
                    if (last_input_in) begin
                        // An exact fill closes the pass on this line;
                        // otherwise the residue goes out next cycle.
                        if (fill == 3'd4) begin
                            last_d = 1'b1;
                        end else begin
                            state_d = FLUSH;
                        end
                    end
                end else if (last_input_in) begin
                    // Partial line, or a bare terminator when fill is 0.
                    valid_d = 1'b1;
                    mask_d  = low_mask(fill);
                    last_d  = 1'b1;
                    cnt_d   = 2'd0;
                    for (int i = 0; i < 4; i++) begin
                        line_d[i] = comb[i];
                    end
                end else begin
                    for (int i = 0; i < 3; i++) begin
                        buf_d[i] = comb[i];
                    end
                    cnt_d = fill[1:0];
                end
            end
            FLUSH: begin
                valid_d = 1'b1;
                mask_d  = low_mask({1'b0, cnt_q});
                last_d  = 1'b1;
                for (int i = 0; i < 3; i++) begin
                    if (2'(i) < cnt_q) begin
                        line_d[i] = buf_q[i];
                    end
                end
                cnt_d   = 2'd0;
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= 2'd0;
            valid_q <= 1'b0;
            mask_q  <= 4'b0000;
            last_q  <= 1'b0;
            words_q <= '0;
            for (int i = 0; i < 3; i++) begin
                buf_q[i] <= '0;
            end
            for (int i = 0; i < 4; i++) begin
                line_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            mask_q  <= mask_d;
            last_q  <= last_d;
            words_q <= words_d;
            for (int i = 0; i < 3; i++) begin
                buf_q[i] <= buf_d[i];
            end
            for (int i = 0; i < 4; i++) begin
                line_q[i] <= line_d[i];
            end
        end
    end

    assign line_out_valid = valid_q;
    assign line_out       = line_q;
    assign line_out_mask  = mask_q;
    assign last_line_out  = last_q;
    assign words_total    = words_q;

endmodule

// File: tb/tb_word_packer.sv
// tb_word_packer: directed tests for word_packer.
// A second small instance exercises counter wrap with CNT_W=4.
module tb_word_packer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;

    logic        a_last;
    logic        a_valid [4];
    logic [63:0] a_word [4];
    logic        a_ov;
    logic [63:0] a_line [4];
    logic [3:0]  a_mask;
    logic        a_lo;
    logic [31:0] a_total;

    logic        b_last;
    logic        b_valid [4];
    logic [7:0]  b_word [4];
    logic        b_ov;
    logic [7:0]  b_line [4];
    logic [3:0]  b_mask;
    logic        b_lo;
    logic [3:0]  b_total;

    int checks = 0;
    int failures = 0;
    int exp_total = 0;

    wire [255:0] a_flat  = {a_line[3], a_line[2], a_line[1], a_line[0]};
    wire [5:0]   a_flags = {a_ov, a_lo, a_mask};

    word_packer #(.W(64), .CNT_W(32)) dut_a (
        .clk           (clk),
        .rst           (rst),
        .last_input_in (a_last),
        .word_in_valid (a_valid),
        .word_in       (a_word),
        .line_out_valid(a_ov),
        .line_out      (a_line),
        .line_out_mask (a_mask),
        .last_line_out (a_lo),
        .words_total   (a_total)
    );

    word_packer #(.W(8), .CNT_W(4)) dut_b (
        .clk           (clk),
        .rst           (rst),
        .last_input_in (b_last),
        .word_in_valid (b_valid),
        .word_in       (b_word),
        .line_out_valid(b_ov),
        .line_out      (b_line),
        .line_out_mask (b_mask),
        .last_line_out (b_lo),
        .words_total   (b_total)
    );

    task automatic a_idle();
        for (int j = 0; j < 4; j++) begin
            a_valid[j] = 1'b0;
            a_word[j]  = '0;
        end
        a_last = 1'b0;
    endtask

    task automatic b_idle();
        for (int j = 0; j < 4; j++) begin
            b_valid[j] = 1'b0;
            b_word[j]  = '0;
        end
        b_last = 1'b0;
    endtask

    // Drive one beat; on return the registered result of it is visible.
    task automatic a_beat(input int n, input logic [63:0] base,
                          input logic last);
        for (int j = 0; j < 4; j++) begin
            a_valid[j] = (j < n);
            a_word[j]  = (j < n) ? base + 64'(j)
                                 : 64'hDEAD_BEEF_0000_0000 + 64'(j);
        end
        a_last = last;
        exp_total += n;
        @(negedge clk);
        a_idle();
    endtask

    task automatic b_beat(input int n, input logic [7:0] base);
        for (int j = 0; j < 4; j++) begin
            b_valid[j] = (j < n);
            b_word[j]  = (j < n) ? base + 8'(j) : 8'hEE;
        end
        b_last = 1'b0;
        @(negedge clk);
        b_idle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_idle();
        b_idle();
        @(negedge clk);
        checks++;
        if (a_flags !== 6'b0)
            begin failures++; $display("FAIL reset_flags got=%b exp=000000", a_flags); end
        checks++;
        if (a_flat !== 256'h0)
            begin failures++; $display("FAIL reset_line got=%h exp=0", a_flat); end
        checks++;
        if (a_total !== 32'd0)
            begin failures++; $display("FAIL reset_total got=%0d exp=0", a_total); end
        rst = 1'b0;
        a_beat(3, 64'h40, 1'b0);
        a_beat(3, 64'h43, 1'b0);
        checks++;
        if (a_flags !== 6'b10_1111)
            begin failures++; $display("FAIL prereset_flags got=%b exp=101111", a_flags); end
        checks++;
        if (a_flat !== {64'h43, 64'h42, 64'h41, 64'h40})
            begin failures++; $display("FAIL prereset_line got=%h", a_flat); end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (a_flags !== 6'b0)
            begin failures++; $display("FAIL midreset_flags got=%b exp=000000", a_flags); end
        checks++;
        if (a_flat !== 256'h0)
            begin failures++; $display("FAIL midreset_line got=%h exp=0", a_flat); end
        checks++;
        if (a_total !== 32'd0)
            begin failures++; $display("FAIL midreset_total got=%0d exp=0", a_total); end
        @(negedge clk);
        rst = 1'b0;
        exp_total = 0;
        a_beat(0, 64'h0, 1'b1);
        checks++;
        if (a_flags !== 6'b11_0000)
            begin failures++; $display("FAIL term_after_reset_flags got=%b exp=110000", a_flags); end
        checks++;
        if (a_flat !== 256'h0)
            begin failures++; $display("FAIL term_after_reset_line got=%h exp=0", a_flat); end
    endtask

    task automatic test_steady();
        logic [63:0] b;
        for (int k = 0; k < 3; k++) begin
            b = 64'h10 + 64'(4 * k);
            a_beat(4, b, 1'b0);
            checks++;
            if (a_flags !== 6'b10_1111)
                begin failures++; $display("FAIL steady_flags%0d got=%b exp=101111", k, a_flags); end
            checks++;
            if (a_flat !== {b + 64'd3, b + 64'd2, b + 64'd1, b})
                begin failures++; $display("FAIL steady_line%0d got=%h", k, a_flat); end
        end
        checks++;
        if (a_total !== 32'd12)
            begin failures++; $display("FAIL steady_total got=%0d exp=12", a_total); end
        @(negedge clk);
        checks++;
        if ({a_flags, a_flat} !== 262'h0)
            begin failures++; $display("FAIL steady_idle got=%b/%h exp=0", a_flags, a_flat); end
    endtask

    task automatic test_carry();
        a_beat(3, 64'hA0, 1'b0);
        checks++;
        if (a_flags !== 6'b0)
            begin failures++; $display("FAIL carry_none got=%b exp=000000", a_flags); end
        a_beat(3, 64'hA3, 1'b0);
        checks++;
        if (a_flags !== 6'b10_1111)
            begin failures++; $display("FAIL carry_flags got=%b exp=101111", a_flags); end
        checks++;
        if (a_flat !== {64'hA3, 64'hA2, 64'hA1, 64'hA0})
            begin failures++; $display("FAIL carry_line got=%h", a_flat); end
        a_beat(0, 64'h0, 1'b1);
        checks++;
        if (a_flags !== 6'b11_0011)
            begin failures++; $display("FAIL carry_rest_flags got=%b exp=110011", a_flags); end
        checks++;
        if (a_flat !== {64'h0, 64'h0, 64'hA5, 64'hA4})
            begin failures++; $display("FAIL carry_rest_line got=%h", a_flat); end
        checks++;
        if (a_total !== 32'(exp_total))
            begin failures++; $display("FAIL carry_total got=%0d exp=%0d", a_total, exp_total); end
    endtask

    task automatic test_flush();
        a_beat(3, 64'hB0, 1'b0);
        a_beat(4, 64'hB3, 1'b1);
        checks++;
        if (a_flags !== 6'b10_1111)
            begin failures++; $display("FAIL flush_full_flags got=%b exp=101111", a_flags); end
        checks++;
        if (a_flat !== {64'hB3, 64'hB2, 64'hB1, 64'hB0})
            begin failures++; $display("FAIL flush_full_line got=%h", a_flat); end
        @(negedge clk);
        checks++;
        if (a_flags !== 6'b11_0111)
            begin failures++; $display("FAIL flush_res_flags got=%b exp=110111", a_flags); end
        checks++;
        if (a_flat !== {64'h0, 64'hB6, 64'hB5, 64'hB4})
            begin failures++; $display("FAIL flush_res_line got=%h", a_flat); end
        @(negedge clk);
        checks++;
        if (a_flags !== 6'b0)
            begin failures++; $display("FAIL flush_after got=%b exp=000000", a_flags); end
        checks++;
        if (a_total !== 32'(exp_total))
            begin failures++; $display("FAIL flush_total got=%0d exp=%0d", a_total, exp_total); end
    endtask

    task automatic test_partial();
        a_beat(1, 64'hC0, 1'b0);
        a_beat(1, 64'hC1, 1'b1);
        checks++;
        if (a_flags !== 6'b11_0011)
            begin failures++; $display("FAIL partial_flags got=%b exp=110011", a_flags); end
        checks++;
        if (a_flat !== {64'h0, 64'h0, 64'hC1, 64'hC0})
            begin failures++; $display("FAIL partial_line got=%h", a_flat); end
        a_beat(0, 64'h0, 1'b1);
        checks++;
        if (a_flags !== 6'b11_0000)
            begin failures++; $display("FAIL empty_flags got=%b exp=110000", a_flags); end
        checks++;
        if (a_flat !== 256'h0)
            begin failures++; $display("FAIL empty_line got=%h exp=0", a_flat); end
    endtask

    task automatic test_exact();
        a_beat(2, 64'hD0, 1'b0);
        a_beat(2, 64'hD2, 1'b1);
        checks++;
        if (a_flags !== 6'b11_1111)
            begin failures++; $display("FAIL exact_flags got=%b exp=111111", a_flags); end
        checks++;
        if (a_flat !== {64'hD3, 64'hD2, 64'hD1, 64'hD0})
            begin failures++; $display("FAIL exact_line got=%h", a_flat); end
        @(negedge clk);
        checks++;
        if (a_flags !== 6'b0)
            begin failures++; $display("FAIL exact_noflush got=%b exp=000000", a_flags); end
    endtask

    task automatic test_back_to_back();
        a_beat(1, 64'hE0, 1'b0);
        a_beat(2, 64'hE1, 1'b0);
        checks++;
        if (a_flags !== 6'b0)
            begin failures++; $display("FAIL b2b_hold got=%b exp=000000", a_flags); end
        a_beat(3, 64'hE3, 1'b0);
        checks++;
        if ({a_flags, a_flat} !== {6'b10_1111, 64'hE3, 64'hE2, 64'hE1, 64'hE0})
            begin failures++; $display("FAIL b2b_line0 got=%b/%h", a_flags, a_flat); end
        a_beat(4, 64'hE6, 1'b0);
        checks++;
        if ({a_flags, a_flat} !== {6'b10_1111, 64'hE7, 64'hE6, 64'hE5, 64'hE4})
            begin failures++; $display("FAIL b2b_line1 got=%b/%h", a_flags, a_flat); end
        a_beat(0, 64'h0, 1'b1);
        checks++;
        if ({a_flags, a_flat} !== {6'b11_0011, 64'h0, 64'h0, 64'hE9, 64'hE8})
            begin failures++; $display("FAIL b2b_tail got=%b/%h", a_flags, a_flat); end
        checks++;
        if (a_total !== 32'd41)
            begin failures++; $display("FAIL b2b_total got=%0d exp=41", a_total); end
    endtask

    task automatic test_wrap();
        b_beat(4, 8'h01);
        b_beat(4, 8'h05);
        b_beat(4, 8'h09);
        b_beat(3, 8'h0D);
        checks++;
        if (b_total !== 4'd15)
            begin failures++; $display("FAIL wrap_pre got=%0d exp=15", b_total); end
        b_beat(2, 8'h10);
        checks++;
        if (b_total !== 4'd1)
            begin failures++; $display("FAIL wrap_post got=%0d exp=1", b_total); end
        checks++;
        if ({b_ov, b_lo, b_mask} !== 6'b10_1111)
            begin failures++; $display("FAIL wrap_line got=%b exp=101111", {b_ov, b_lo, b_mask}); end
    endtask

    initial begin
        test_reset();
        test_steady();
        test_carry();
        test_flush();
        test_partial();
        test_exact();
        test_back_to_back();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
